wdog_modport: RTL and testbench
===============================

WDOG_MODPORT -- requirements
Module: wdog_modport

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 pclk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 PRESET, input, 1: asynchronous active-high reset.
REQ-004 PADDR, input, 32: APB address; only PADDR[11:2] decoded.
REQ-005 PSEL, PENABLE, PWRITE, input, 1 each: APB select, access phase, write strobe.
REQ-006 PWDATA, input, 32 / PRDATA, output, 32: APB write / read data.
REQ-007 PREADY, output, 1: constant 1; no wait states.
REQ-008 WDOGCLKEN, input, 1: count tick qualifier, one pclk cycle per tick.
REQ-009 WDOGINT, output, 1: interrupt = RIS AND INTEN.
REQ-010 WDOGRES, output, 1: watchdog reset request, registered.

Function
REQ-011 Write SHALL occur when PSEL & PENABLE & PWRITE; setup phase has no effect.
REQ-012 PRDATA SHALL be the addressed register when PSEL & !PWRITE, else 0; unmapped and write-only offsets read 0.
REQ-013 Register map by byte offset:
- 0x000 LOAD, RW 32
- 0x004 VALUE, RO current counter
- 0x008 CONTROL, RW; bit0 INTEN, bit1 RESEN, other bits read 0
- 0x00C INTCLR, WO; any data
- 0x010 RIS, RO bit0
- 0x014 MIS, RO bit0 = RIS & INTEN
- 0xC00 LOCK, RW
REQ-014 Writing LOAD SHALL also load the counter with PWDATA on the same edge.
REQ-015 Writing INTCLR SHALL clear RIS and reload the counter from LOAD.
REQ-016 Writing CONTROL with INTEN 0->1 SHALL reload the counter from LOAD.
REQ-017 Counter SHALL only change on a tick: pclk edge with WDOGCLKEN=1 and INTEN=1.
REQ-018 On a tick with counter > 1: counter decrements by 1.
REQ-019 On a tick with counter <= 1, the block SHALL:
- reload the counter from LOAD
- set RIS
- set WDOGRES if RIS was already 1 and RESEN=1
REQ-020 LOAD=0 SHALL cause an expiry on every tick; first interrupt after LOAD=N (N>=1) SHALL occur on the Nth tick.
REQ-021 WDOGRES SHALL be sticky until PRESET; clearing RESEN or RIS does not clear it.
REQ-022 Writing 0x1ACCE551 to LOCK SHALL unlock; any other value SHALL lock.
REQ-023 LOCK SHALL read 0x00000001 when locked, 0 when unlocked.
REQ-024 While locked, writes to LOAD, CONTROL and INTCLR SHALL be ignored; LOCK remains writable.
REQ-025 Same-edge priority SHALL be: register write (LOAD/INTCLR/INTEN-rise reload) over tick decrement/expiry.
REQ-026 A tick is ignored on the same edge as an INTCLR write, so RIS stays 0 and WDOGRES is not set.
REQ-027 Counter arithmetic SHALL be 32-bit unsigned with no wrap below 0.

Reset
REQ-028 PRESET SHALL immediately set:
- LOAD = 0xFFFFFFFF, counter = 0xFFFFFFFF
- CONTROL = 0, RIS = 0
- WDOGRES = 0, WDOGINT = 0
- unlocked
REQ-029 While PRESET is high, APB writes and ticks SHALL be ignored.
REQ-030 PRESET SHALL take effect mid-count with no residual state.
REQ-031 PRDATA and PREADY SHALL be unaffected by reset (combinational/constant).

Verification
REQ-032 Reset, read all registers -> LOAD=VALUE=0xFFFFFFFF, CONTROL=RIS=MIS=LOCK=0, WDOGINT=WDOGRES=0.
REQ-033 LOAD=5, CONTROL=0x1, WDOGCLKEN=1 every cycle -> WDOGINT rises after 5th tick, VALUE reloads to 5.
REQ-034 LOAD=3, CONTROL=0x3, no INTCLR -> WDOGINT at tick 3, WDOGRES at tick 6, WDOGRES stays 1 until PRESET.
REQ-035 Same as REQ-034 but write INTCLR after WDOGINT -> RIS=0, VALUE=3, WDOGRES never asserts.
REQ-036 Write LOCK=0 then LOAD=7 -> LOAD unchanged, LOCK reads 1; write LOCK=0x1ACCE551 then LOAD=7 -> LOAD=7, LOCK reads 0.
REQ-037 WDOGCLKEN toggled 1/0 with LOAD=4, INTEN=1 -> expiry after 4 enabled cycles (8 pclk); PRESET asserted mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/wdog_modport.sv
// APB watchdog: down-counter with interrupt, reset request and lock.
// Counts on WDOGCLKEN ticks while INTEN is set.
module wdog_modport (
  input  logic        pclk,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        WDOGCLKEN,
  output logic        WDOGINT,
  output logic        WDOGRES
);

  localparam logic [9:0] A_LOAD = 10'h000;
  localparam logic [9:0] A_VAL  = 10'h001;
  localparam logic [9:0] A_CTRL = 10'h002;
  localparam logic [9:0] A_CLR  = 10'h003;
  localparam logic [9:0] A_RIS  = 10'h004;
  localparam logic [9:0] A_MIS  = 10'h005;
  localparam logic [9:0] A_LOCK = 10'h300;

  localparam logic [31:0] KEY = 32'h1ACC_E551;

  logic [31:0] load;
  logic [31:0] count;
  logic        inten;
  logic        resen;
  logic        ris;
  logic        locked;
  logic        res;

  logic [9:0]  off;
  logic        wr;
  logic        open;
  logic        wr_lock;
  logic        wr_load;
  logic        wr_ctrl;
  logic        wr_clr;
  logic        rise;
  logic        tick;
  logic        expire;
  logic        unused_ok;

  assign off       = PADDR[11:2];
  assign unused_ok = ^{PADDR[31:12], PADDR[1:0]};

  assign wr      = PSEL & PENABLE & PWRITE;
  assign open    = wr & ~locked;
  assign wr_lock = wr & (off == A_LOCK);
  assign wr_load = open & (off == A_LOAD);
  assign wr_ctrl = open & (off == A_CTRL);
  assign wr_clr  = open & (off == A_CLR);
  assign rise    = wr_ctrl & PWDATA[0] & ~inten;

  // Any register-driven reload swallows a tick on the same edge.
  assign tick   = WDOGCLKEN & inten & ~wr_load & ~wr_clr & ~rise;
  assign expire = tick & (count <= 32'd1);

  assign PREADY  = 1'b1;
  assign WDOGINT = ris & inten;
  assign WDOGRES = res;

  // Register file, counter and sticky reset request.
  always_ff @(posedge pclk or posedge PRESET) begin
    if (PRESET) begin
      load   <= 32'hFFFF_FFFF;
      count  <= 32'hFFFF_FFFF;
      inten  <= 1'b0;
      resen  <= 1'b0;
      ris    <= 1'b0;
      locked <= 1'b0;
      res    <= 1'b0;
    end else begin
      if (wr_lock)
        locked <= (PWDATA != KEY);
      if (wr_load)
        load <= PWDATA;
      if (wr_ctrl) begin
        inten <= PWDATA[0];
        resen <= PWDATA[1];
      end
      if (wr_load)
        count <= PWDATA;
      else if (wr_clr || rise)
        count <= load;
      else if (expire)
        count <= load;
      else if (tick)
        count <= count - 32'd1;
      if (wr_clr)
        ris <= 1'b0;
      else if (expire)
        ris <= 1'b1;
      if (expire && ris && resen)
        res <= 1'b1;
    end
  end

  // Read mux; only a selected read drives data.
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      case (off)
        A_LOAD:  PRDATA = load;
        A_VAL:   PRDATA = count;
        A_CTRL:  PRDATA = {30'd0, resen, inten};
        A_RIS:   PRDATA = {31'd0, ris};
        A_MIS:   PRDATA = {31'd0, ris & inten};
        A_LOCK:  PRDATA = {31'd0, locked};
        default: PRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_wdog_modport.sv
// Directed bench for wdog_modport.
// Inputs change on negedge; outputs sampled away from posedge.
module tb_wdog_modport;

  logic        pclk = 1'b0;
  logic        PRESET = 1'b1;
  logic [31:0] PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        WDOGCLKEN = 1'b0;
  logic        WDOGINT;
  logic        WDOGRES;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] LOAD = 32'h000;
  localparam logic [31:0] VAL  = 32'h004;
  localparam logic [31:0] CTRL = 32'h008;
  localparam logic [31:0] CLR  = 32'h00C;
  localparam logic [31:0] RIS  = 32'h010;
  localparam logic [31:0] MIS  = 32'h014;
  localparam logic [31:0] LOCK = 32'hC00;

  wdog_modport dut (
    .pclk(pclk), .PRESET(PRESET),
    .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .WDOGCLKEN(WDOGCLKEN),
    .WDOGINT(WDOGINT), .WDOGRES(WDOGRES)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic tk = 1'b0);
    @(negedge pclk);
    PADDR = a; PWDATA = d;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    @(negedge pclk);
    PENABLE = 1'b1;
    WDOGCLKEN = tk;
    @(negedge pclk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    WDOGCLKEN = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    @(negedge pclk);
    PADDR = a; PSEL = 1'b1;
    PWRITE = 1'b0; PENABLE = 1'b1;
    #1;
    chk(tag, PRDATA, exp);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic ticks(input int n);
    @(negedge pclk);
    WDOGCLKEN = 1'b1;
    repeat (n) @(negedge pclk);
    WDOGCLKEN = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    PRESET = 1'b1;
    @(negedge pclk);
    PRESET = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge pclk);
    PRESET = 1'b0;

    rd("rst_load", LOAD, 32'hFFFF_FFFF);
    rd("rst_val", VAL, 32'hFFFF_FFFF);
    rd("rst_ctrl", CTRL, 32'd0);
    rd("rst_ris", RIS, 32'd0);
    rd("rst_mis", MIS, 32'd0);
    rd("rst_lock", LOCK, 32'd0);
    rd("rd_clr", CLR, 32'd0);
    rd("rd_unmap", 32'h018, 32'd0);
    chk("rst_int", {31'd0, WDOGINT}, 32'd0);
    chk("rst_res", {31'd0, WDOGRES}, 32'd0);
    chk("pready", {31'd0, PREADY}, 32'd1);

    apb_wr(LOAD, 32'd5);
    apb_wr(CTRL, 32'h1);
    rd("a_val", VAL, 32'd5);
    ticks(4);
    rd("a_val4", VAL, 32'd1);
    chk("a_int4", {31'd0, WDOGINT}, 32'd0);
    ticks(1);
    chk("a_int5", {31'd0, WDOGINT}, 32'd1);
    rd("a_reload", VAL, 32'd5);
    rd("a_mis", MIS, 32'd1);

    do_reset();
    apb_wr(LOAD, 32'd3);
    apb_wr(CTRL, 32'h3);
    ticks(3);
    chk("b_int3", {31'd0, WDOGINT}, 32'd1);
    chk("b_res3", {31'd0, WDOGRES}, 32'd0);
    ticks(2);
    chk("b_res5", {31'd0, WDOGRES}, 32'd0);
    ticks(1);
    chk("b_res6", {31'd0, WDOGRES}, 32'd1);
    apb_wr(CTRL, 32'h0);
    chk("b_sticky", {31'd0, WDOGRES}, 32'd1);
    chk("b_int_off", {31'd0, WDOGINT}, 32'd0);
    rd("b_ris", RIS, 32'd1);
    do_reset();
    chk("b_res_rst", {31'd0, WDOGRES}, 32'd0);

    apb_wr(LOAD, 32'd3);
    apb_wr(CTRL, 32'h3);
    ticks(3);
    chk("c_int3", {31'd0, WDOGINT}, 32'd1);
    apb_wr(CLR, 32'h0);
    rd("c_ris", RIS, 32'd0);
    rd("c_val", VAL, 32'd3);
    ticks(3);
    chk("c_int6", {31'd0, WDOGINT}, 32'd1);
    chk("c_res6", {31'd0, WDOGRES}, 32'd0);
    apb_wr(CLR, 32'h0);
    apb_wr(LOAD, 32'd1);
    apb_wr(CLR, 32'h0, 1'b1);
    rd("c_clr_tick", RIS, 32'd0);
    rd("c_clr_val", VAL, 32'd1);
    chk("c_clr_res", {31'd0, WDOGRES}, 32'd0);

    do_reset();
    apb_wr(LOCK, 32'h0);
    rd("d_locked", LOCK, 32'd1);
    apb_wr(LOAD, 32'd7);
    rd("d_load_blk", LOAD, 32'hFFFF_FFFF);
    apb_wr(CTRL, 32'h3);
    rd("d_ctrl_blk", CTRL, 32'd0);
    apb_wr(LOCK, 32'h1ACC_E551);
    rd("d_unlock", LOCK, 32'd0);
    apb_wr(LOAD, 32'd7);
    rd("d_load", LOAD, 32'd7);
    rd("d_val", VAL, 32'd7);
    apb_wr(CTRL, 32'hFFFF_FFFC);
    rd("d_ctrl_msk", CTRL, 32'd0);

    do_reset();
    apb_wr(LOAD, 32'd4);
    apb_wr(CTRL, 32'h3);
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      WDOGCLKEN = (i % 2 == 0);
    end
    @(negedge pclk);
    WDOGCLKEN = 1'b0;
    rd("e_val3", VAL, 32'd1);
    chk("e_int6", {31'd0, WDOGINT}, 32'd0);
    @(negedge pclk);
    WDOGCLKEN = 1'b1;
    @(negedge pclk);
    WDOGCLKEN = 1'b0;
    chk("e_int8", {31'd0, WDOGINT}, 32'd1);
    rd("e_val", VAL, 32'd4);
    ticks(4);
    chk("e_res", {31'd0, WDOGRES}, 32'd1);
    ticks(2);
    #2 PRESET = 1'b1;
    #1;
    chk("e_rst_int", {31'd0, WDOGINT}, 32'd0);
    chk("e_rst_res", {31'd0, WDOGRES}, 32'd0);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = VAL;
    #1;
    chk("e_rst_val", PRDATA, 32'hFFFF_FFFF);
    PSEL = 1'b0;
    @(negedge pclk);
    PRESET = 1'b0;

    apb_wr(LOAD, 32'd0);
    apb_wr(CTRL, 32'h1);
    ticks(1);
    rd("f_ris0", RIS, 32'd1);
    rd("f_val0", VAL, 32'd0);
    apb_wr(CLR, 32'h0);
    ticks(1);
    rd("f_ris1", RIS, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
